// File: rtl/packet_link_arbiter_if.sv
// Requester, link and status bundle for packet_link_arbiter.
// master drives pacing/requests/credits; slave is the arbiter.
interface packet_link_arbiter_if #(
  parameter int PACKET_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int CREDITS = 4
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int IW = $clog2(NUM_REQ);

  logic                            tick;
  logic                            enable;
  logic [NUM_REQ-1:0]              req_empty;
  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]              req_pop;
  logic [PACKET_WIDTH-1:0]         packet_out;
  logic                            packet_out_valid;
  logic                            credit_return;
  logic [IW-1:0]                   grant_id;
  logic [CW-1:0]                   credits_avail;
  logic                            credit_err;

  modport master (
    output tick, enable, req_empty, req_data, credit_return,
    input  req_pop, packet_out, packet_out_valid,
    input  grant_id, credits_avail, credit_err
  );

  modport slave (
    input  tick, enable, req_empty, req_data, credit_return,
    output req_pop, packet_out, packet_out_valid,
    output grant_id, credits_avail, credit_err
  );
endinterface

// File: rtl/packet_link_arbiter.sv
// Credit-gated round-robin arbiter sharing one packet link
// between NUM_REQ FWFT requester FIFOs, one issue per tick.
module packet_link_arbiter #(
  parameter int PACKET_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int CREDITS = 4,
  localparam int CW = $clog2(CREDITS + 1),
  localparam int IW = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  packet_link_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PEND, ISSUE} state_t;

  state_t state, state_nx;

  logic [IW-1:0]           gid_q;
  logic [IW-1:0]           sel;
  logic [IW-1:0]           scan_idx;
  logic                    found;
  logic [CW-1:0]           cred_q;
  logic                    err_q;
  logic                    valid_q;
  logic [NUM_REQ-1:0]      pop_q;
  logic [PACKET_WIDTH-1:0] pkt_q;
  logic                    eligible;
  logic                    go;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_REQ);
  endfunction

  assign eligible = bus.enable
                 && (cred_q != '0)
                 && (bus.req_empty != '1);

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.tick && eligible) begin
          state_nx = ISSUE;
          go       = 1'b1;
        end else if (bus.tick && bus.enable) begin
          state_nx = PEND;
        end
      end
      PEND: begin
        if (eligible) begin
          state_nx = ISSUE;
          go       = 1'b1;
        end else if (!bus.enable) begin
          state_nx = IDLE;
        end
      end
      ISSUE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Scan upward from the requester after the last grant.
  always_comb begin
    sel      = gid_q;
    scan_idx = gid_q;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = wrap(int'(gid_q) + k);
      if (!found && !bus.req_empty[scan_idx]) begin
        sel   = scan_idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pop_q   <= '0;
      pkt_q   <= '0;
      gid_q   <= IW'(NUM_REQ - 1);
    end else begin
      valid_q <= go;
      pop_q   <= go ? (NUM_REQ'(1) << sel) : '0;
      if (go) begin
        pkt_q <= bus.req_data[sel*PACKET_WIDTH +: PACKET_WIDTH];
        gid_q <= sel;
      end
    end
  end

  // Issue and return in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred_q <= CW'(CREDITS);
      err_q  <= 1'b0;
    end else if (go && !bus.credit_return) begin
      cred_q <= cred_q - CW'(1);
    end else if (!go && bus.credit_return) begin
      if (cred_q == CW'(CREDITS)) begin
        err_q <= 1'b1;
      end else begin
        cred_q <= cred_q + CW'(1);
      end
    end
  end

  assign bus.packet_out       = pkt_q;
  assign bus.packet_out_valid = valid_q;
  assign bus.req_pop          = pop_q;
  assign bus.grant_id         = gid_q;
  assign bus.credits_avail    = cred_q;
  assign bus.credit_err       = err_q;

endmodule

// File: tb/tb_packet_link_arbiter.sv
// Bench for packet_link_arbiter: directed scenarios plus random
// traffic against a permit/credit reference model.
module tb_packet_link_arbiter;
  localparam int PW = 32;
  localparam int NR = 4;
  localparam int CR = 4;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int failures = 0;

  packet_link_arbiter_if #(
    .PACKET_WIDTH(PW), .NUM_REQ(NR), .CREDITS(CR)
  ) bus ();

  packet_link_arbiter #(
    .PACKET_WIDTH(PW), .NUM_REQ(NR), .CREDITS(CR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: a latched "permit" plus a credit count.
  bit          m_permit;
  bit          m_issuing;
  bit          m_valid;
  logic [NR-1:0] m_pop;
  logic [PW-1:0] m_pkt;
  int          m_gid;
  int          m_cred;
  bit          m_err;
  bit          m_go;
  bit          m_want;
  int          m_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_permit  = 0;
      m_issuing = 0;
      m_valid   = 0;
      m_pop     = '0;
      m_pkt     = '0;
      m_gid     = NR - 1;
      m_cred    = CR;
      m_err     = 0;
    end else begin
      m_go  = 0;
      m_sel = -1;
      if (!bus.enable) begin
        m_permit = 0;
      end else if (!m_issuing) begin
        m_want = m_permit || bus.tick;
        for (int k = 1; k <= NR; k++) begin
          if (m_sel < 0 && !bus.req_empty[(m_gid + k) % NR])
            m_sel = (m_gid + k) % NR;
        end
        if (m_want && m_cred > 0 && m_sel >= 0) begin
          m_go     = 1;
          m_permit = 0;
        end else begin
          m_permit = m_want;
        end
      end
      if (m_go && !bus.credit_return) begin
        m_cred = m_cred - 1;
      end else if (!m_go && bus.credit_return) begin
        if (m_cred == CR) m_err = 1;
        else m_cred = m_cred + 1;
      end
      m_issuing = m_go;
      m_valid   = m_go;
      m_pop     = m_go ? NR'(1 << m_sel) : '0;
      if (m_go) begin
        m_pkt = bus.req_data[m_sel*PW +: PW];
        m_gid = m_sel;
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_valid", 64'(bus.packet_out_valid), 64'(m_valid));
    chk("cyc_pop", 64'(bus.req_pop), 64'(m_pop));
    chk("cyc_pkt", 64'(bus.packet_out), 64'(m_pkt));
    chk("cyc_gid", 64'(bus.grant_id), 64'(m_gid));
    chk("cyc_cred", 64'(bus.credits_avail), 64'(m_cred));
    chk("cyc_err", 64'(bus.credit_err), 64'(m_err));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  int ord[5] = '{0, 1, 2, 3, 0};
  int nvalid;

  initial begin
    rst               = 1'b1;
    bus.tick          = 1'b0;
    bus.enable        = 1'b0;
    bus.credit_return = 1'b0;
    bus.req_empty     = '1;
    bus.req_data      = '0;
    cyc();
    cyc();
    chk("rst_valid", 64'(bus.packet_out_valid), 64'd0);
    chk("rst_pop", 64'(bus.req_pop), 64'd0);
    chk("rst_pkt", 64'(bus.packet_out), 64'd0);
    chk("rst_gid", 64'(bus.grant_id), 64'd3);
    chk("rst_cred", 64'(bus.credits_avail), 64'd4);
    chk("rst_err", 64'(bus.credit_err), 64'd0);
    rst = 1'b0;

    // Single requester.
    bus.enable = 1'b1;
    bus.req_empty = 4'b1011;
    bus.req_data[2*PW +: PW] = 32'hA5A5_0002;
    idle(8);
    pulse_tick();
    chk("single_valid", 64'(bus.packet_out_valid), 64'd1);
    chk("single_pop", 64'(bus.req_pop), 64'b0100);
    chk("single_pkt", 64'(bus.packet_out), 64'hA5A5_0002);
    chk("single_gid", 64'(bus.grant_id), 64'd2);
    chk("single_cred", 64'(bus.credits_avail), 64'd3);
    cyc();
    chk("single_valid_drop", 64'(bus.packet_out_valid), 64'd0);
    chk("single_pkt_hold", 64'(bus.packet_out), 64'hA5A5_0002);
    bus.credit_return = 1'b1;
    cyc();
    bus.credit_return = 1'b0;
    chk("single_cred_back", 64'(bus.credits_avail), 64'd4);

    // Round robin.
    do_reset();
    bus.req_empty = '0;
    for (int i = 0; i < NR; i++) bus.req_data[i*PW +: PW] = PW'(32'h100 + i);
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      chk("rr_gid", 64'(bus.grant_id), 64'(ord[i]));
      chk("rr_pop", 64'(bus.req_pop), 64'(1 << ord[i]));
      chk("rr_pkt", 64'(bus.packet_out), 64'(32'h100 + ord[i]));
      bus.credit_return = 1'b1;
      cyc();
      bus.credit_return = 1'b0;
      idle(2);
    end

    // Credit stall.
    do_reset();
    bus.req_empty = '0;
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      idle(3);
    end
    chk("stall_cred", 64'(bus.credits_avail), 64'd0);
    chk("stall_valid", 64'(bus.packet_out_valid), 64'd0);
    bus.credit_return = 1'b1;
    cyc();
    bus.credit_return = 1'b0;
    chk("stall_c1_valid", 64'(bus.packet_out_valid), 64'd0);
    cyc();
    chk("stall_c2_valid", 64'(bus.packet_out_valid), 64'd1);
    chk("stall_c2_cred", 64'(bus.credits_avail), 64'd0);
    chk("stall_c2_gid", 64'(bus.grant_id), 64'd0);

    // Simultaneous issue and return, then ticks during PEND.
    bus.credit_return = 1'b1;
    cyc();
    cyc();
    bus.credit_return = 1'b0;
    chk("simul_pre_cred", 64'(bus.credits_avail), 64'd2);
    bus.tick = 1'b1;
    bus.credit_return = 1'b1;
    cyc();
    bus.tick = 1'b0;
    bus.credit_return = 1'b0;
    chk("simul_valid", 64'(bus.packet_out_valid), 64'd1);
    chk("simul_cred", 64'(bus.credits_avail), 64'd2);
    cyc();
    bus.req_empty = '1;
    pulse_tick();
    idle(1);
    pulse_tick();
    pulse_tick();
    bus.req_empty = 4'b1110;
    nvalid = 0;
    repeat (8) begin
      cyc();
      if (bus.packet_out_valid) nvalid++;
    end
    chk("pend_one_issue", 64'(nvalid), 64'd1);

    // Overflow.
    do_reset();
    bus.credit_return = 1'b1;
    cyc();
    bus.credit_return = 1'b0;
    chk("ovf_cred", 64'(bus.credits_avail), 64'd4);
    chk("ovf_err", 64'(bus.credit_err), 64'd1);
    bus.req_empty = '0;
    pulse_tick();
    idle(3);
    chk("ovf_err_sticky", 64'(bus.credit_err), 64'd1);
    do_reset();
    chk("ovf_err_clr", 64'(bus.credit_err), 64'd0);

    // Reset during ISSUE.
    bus.req_empty = 4'b1101;
    pulse_tick();
    chk("mid_valid_pre", 64'(bus.packet_out_valid), 64'd1);
    chk("mid_gid_pre", 64'(bus.grant_id), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_valid", 64'(bus.packet_out_valid), 64'd0);
    chk("mid_pop", 64'(bus.req_pop), 64'd0);
    chk("mid_cred", 64'(bus.credits_avail), 64'd4);
    chk("mid_gid", 64'(bus.grant_id), 64'd3);
    cyc();
    rst = 1'b0;
    bus.req_empty = 4'b1110;
    idle(2);
    pulse_tick();
    chk("mid_next_valid", 64'(bus.packet_out_valid), 64'd1);
    chk("mid_next_gid", 64'(bus.grant_id), 64'd0);

    // Random traffic.
    do_reset();
    repeat (3000) begin
      rst               = ($urandom % 400) == 0;
      bus.tick          = ($urandom % 4) == 0;
      bus.enable        = ($urandom % 16) != 0;
      bus.req_empty     = NR'($urandom);
      bus.req_data      = {$urandom, $urandom, $urandom, $urandom};
      bus.credit_return = ($urandom % 3) == 0;
      cyc();
    end
    rst = 1'b0;
    bus.tick = 1'b0;
    bus.credit_return = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/packet_link_arbiter.md
Name: packet_link_arbiter

Overview:
- Round-robin scheduler that shares the single test_send → test_receive packet link between NUM_REQ packet sources.
- Issues at most one packet per tick, only while the receive buffer has space.
- Receive-buffer space is tracked with a credit counter; credits are returned by the receiver on each read.
- Sits between the requester FIFOs and the link's packet_out / packet_out_valid.

Parameters:
- PACKET_WIDTH, 32: width of each packet.
- NUM_REQ, 4: number of requesters, ≥2.
- CREDITS, 4: receive-buffer depth, i.e. initial and maximum credit count, ≥1.
- CW, $clog2(CREDITS+1): width of the credit counter.
- IW, $clog2(NUM_REQ): width of the grant index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- tick  in  1  single-cycle pacing pulse; each pulse permits one issue.
- enable  in  1  0 = hold in IDLE and ignore ticks.
- req_empty  in  NUM_REQ  per-requester FIFO empty flag; FIFOs are first-word-fall-through.
- req_data  in  NUM_REQ*PACKET_WIDTH  head word of each requester; slice i = bits [i*PW +: PW].
- req_pop  out  NUM_REQ  one-hot, one-cycle pop of the granted FIFO.
- packet_out  out  PACKET_WIDTH  issued packet.
- packet_out_valid  out  1  one-cycle strobe.
- credit_return  in  1  one-cycle pulse per word the receiver consumes.
- grant_id  out  IW  index of the last granted requester.
- credits_avail  out  CW  current credit count.
- credit_err  out  1  sticky overflow flag.

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE.
  - packet_out=0, packet_out_valid=0, req_pop=0.
  - grant_id=NUM_REQ-1, so requester 0 has first priority.
  - credits_avail=CREDITS, credit_err=0.
- eligible = enable && (credits_avail != 0) && (req_empty != all-ones).
- FSM states: IDLE, PEND, ISSUE.
  - IDLE: if tick && eligible → ISSUE; if tick && !eligible && enable → PEND; otherwise stay.
  - PEND (a tick is latched): if eligible → ISSUE; if enable==0 → IDLE (the pending tick is discarded); otherwise stay.
  - ISSUE: lasts exactly one cycle, then → IDLE unconditionally.
- Ticks arriving in PEND or ISSUE are dropped and do not accumulate.
- Entering ISSUE, on the clock edge of the transition:
  - sel = first non-empty requester scanning (grant_id+1) mod NUM_REQ upward, with wrap-around.
  - packet_out <= req_data[sel]; grant_id <= sel.
  - The credit is reserved on this edge.
- While in ISSUE: packet_out_valid=1 and req_pop=one-hot(sel); both are registered, with no combinational path from inputs.
- packet_out holds its value after ISSUE until the next issue.
- Latency: tick sampled in IDLE at cycle T with eligible=1 → packet_out_valid at T+1. From PEND: eligible at cycle T → valid at T+1.
- Credits:
  - Decrement when entering ISSUE; increment on credit_return.
  - Both in the same cycle → unchanged.
  - credit_return at credits_avail==CREDITS with no decrement → count saturates and credit_err is set; it clears only on rst.
  - The count never underflows, because eligibility requires a credit.
- Requester FIFO emptying between grant and pop is not possible: the FIFO is popped only by this block.
- rst asserted mid-ISSUE: valid and pop drop immediately, and the in-flight packet is lost.

Test Plan:
- Single requester: NUM_REQ=4, CREDITS=4. Only req 2 non-empty, data 0xA5A5_0002, tick at cycle 10 → packet_out_valid=1 and req_pop=4'b0100 at cycle 11, packet_out=0xA5A5_0002, grant_id=2, credits_avail=3.
- Round-robin: all four non-empty, ticks every 4 cycles, credit_return after each issue → grant order 0,1,2,3,0, with req_pop one-hot matching each issue.
- Credit stall: no credit_return; five ticks with all non-empty → 4 issues, credits_avail=0, FSM in PEND. A credit_return at cycle C → issue with valid at C+2, credits_avail back to 0.
- Simultaneous events: credit_return in the same cycle as the ISSUE entry at credits_avail=2 → stays 2. Extra ticks during PEND → exactly one issue.
- Overflow: credit_return at credits_avail=4 → stays 4, credit_err=1, and it remains 1 until rst.
- Reset mid-op: assert rst during the ISSUE cycle → valid and pop 0 immediately, credits_avail=4, grant_id=3. The next tick with req 0 non-empty grants req 0.
